// File: rtl/pdp8_timing_ctl.sv
// Major-cycle timing sequencer for the PDP-8/I model: TS1-TS4 time states, TP1-TP4
// time pulses, RUN flip-flop, console start/continue/stop and halt handling.
module pdp8_timing_ctl #(
  parameter int TS1_CLKS = 4,
  parameter int TS2_CLKS = 4,
  parameter int TS3_CLKS = 4,
  parameter int TS4_CLKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_cont,
  input  logic       key_stop,
  input  logic       sw_sing_step,
  input  logic       sw_sing_inst,
  input  logic       hlt_req,
  input  logic       inst_done,
  input  logic       io_pause,
  output logic [3:0] ts,
  output logic [3:0] tp,
  output logic       run,
  output logic       mem_start,
  output logic       start_clear
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TS1,
    ST_TS2,
    ST_TS3,
    ST_TS4
  } state_t;

  localparam logic [3:0] LAST1 = 4'(TS1_CLKS - 1);
  localparam logic [3:0] LAST2 = 4'(TS2_CLKS - 1);
  localparam logic [3:0] LAST3 = 4'(TS3_CLKS - 1);
  localparam logic [3:0] LAST4 = 4'(TS4_CLKS - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stop_pend_q, stop_pend_d;
  logic       run_q, run_d;
  logic [3:0] ts_q, ts_d;
  logic       mem_start_q, mem_start_d;
  logic       start_clear_q, start_clear_d;
  logic       halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      stop_pend_q   <= 1'b0;
      run_q         <= 1'b0;
      ts_q          <= 4'd0;
      mem_start_q   <= 1'b0;
      start_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stop_pend_q   <= stop_pend_d;
      run_q         <= run_d;
      ts_q          <= ts_d;
      mem_start_q   <= mem_start_d;
      start_clear_q <= start_clear_d;
    end
  end

  assign halt = stop_pend_q | key_stop | sw_sing_step | hlt_req | (sw_sing_inst & inst_done);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    run_d         = run_q;
    mem_start_d   = 1'b0;
    start_clear_d = 1'b0;
    tp            = 4'd0;
    // A stop requested mid-cycle is remembered until the cycle ends; IDLE entry clears it below.
    stop_pend_d   = stop_pend_q | (key_stop & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (key_start | key_cont) begin
          state_d       = ST_TS1;
          cnt_d         = 4'd0;
          run_d         = 1'b1;
          mem_start_d   = 1'b1;
          start_clear_d = key_start;
          stop_pend_d   = key_stop;
        end
      end
      ST_TS1: begin
        if (cnt_q == LAST1) begin
          tp[0]   = 1'b1;
          state_d = ST_TS2;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_TS2: begin
        if (cnt_q == LAST2) begin
          tp[1]   = 1'b1;
          state_d = ST_TS3;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_TS3: begin
        // io_pause parks TS3 at its terminal count with TP3 held back.
        if (cnt_q == LAST3) begin
          if (!io_pause) begin
            tp[2]   = 1'b1;
            state_d = ST_TS4;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_TS4: begin
        if (cnt_q == LAST4) begin
          tp[3] = 1'b1;
          cnt_d = 4'd0;
          if (halt) begin
            state_d     = ST_IDLE;
            run_d       = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            state_d     = ST_TS1;
            mem_start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        run_d   = 1'b0;
      end
    endcase

    case (state_d)
      ST_TS1:  ts_d = 4'b0001;
      ST_TS2:  ts_d = 4'b0010;
      ST_TS3:  ts_d = 4'b0100;
      ST_TS4:  ts_d = 4'b1000;
      default: ts_d = 4'b0000;
    endcase
  end

  assign ts          = ts_q;
  assign run         = run_q;
  assign mem_start   = mem_start_q;
  assign start_clear = start_clear_q;

endmodule

// File: tb/tb_pdp8_timing_ctl.sv
// Bench for pdp8_timing_ctl: directed console scenarios plus random stimulus,
// checked every clock against a position-in-cycle reference model.
module tb_pdp8_timing_ctl;

  localparam int T1 = 4;
  localparam int T2 = 4;
  localparam int T3 = 4;
  localparam int T4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0, key_cont = 1'b0, key_stop = 1'b0;
  logic       sw_sing_step = 1'b0, sw_sing_inst = 1'b0;
  logic       hlt_req = 1'b0, inst_done = 1'b0, io_pause = 1'b0;
  logic [3:0] ts, tp;
  logic       run, mem_start, start_clear;

  int nChecks = 0;
  int nFails  = 0;
  int msCount, scCount, runCount;

  // Reference model: running flag, clock position inside the memory cycle,
  // position at which TP3 fired (-1 until it has), pending stop, clear flag.
  bit mRun = 1'b0, mStop = 1'b0, mClear = 1'b0;
  int mPos = 0, mTp3 = -1;

  always #5 clk = ~clk;

  pdp8_timing_ctl #(
    .TS1_CLKS(T1), .TS2_CLKS(T2), .TS3_CLKS(T3), .TS4_CLKS(T4)
  ) dut (
    .clk(clk), .rst(rst),
    .key_start(key_start), .key_cont(key_cont), .key_stop(key_stop),
    .sw_sing_step(sw_sing_step), .sw_sing_inst(sw_sing_inst),
    .hlt_req(hlt_req), .inst_done(inst_done), .io_pause(io_pause),
    .ts(ts), .tp(tp), .run(run), .mem_start(mem_start), .start_clear(start_clear)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelOutputs(output logic [3:0] eTs, output logic [3:0] eTp,
                                       output logic eRun, output logic eMs, output logic eSc);
    eTs = 4'd0; eTp = 4'd0; eRun = mRun; eMs = 1'b0; eSc = 1'b0;
    if (mRun) begin
      eMs = (mPos == 0);
      eSc = (mPos == 0) && mClear;
      if (mPos < T1) begin
        eTs = 4'b0001; eTp[0] = (mPos == T1 - 1);
      end else if (mPos < T1 + T2) begin
        eTs = 4'b0010; eTp[1] = (mPos == T1 + T2 - 1);
      end else if (mTp3 < 0) begin
        eTs = 4'b0100; eTp[2] = (mPos >= T1 + T2 + T3 - 1) && !io_pause;
      end else begin
        eTs = 4'b1000; eTp[3] = (mPos == mTp3 + T4);
      end
    end
  endfunction

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic modelUpdate();
    logic [3:0] eTs, eTp;
    logic eRun, eMs, eSc;
    bit halt;
    modelOutputs(eTs, eTp, eRun, eMs, eSc);
    if (rst) begin
      mRun = 1'b0; mStop = 1'b0;
    end else if (!mRun) begin
      if (key_start || key_cont) begin
        mRun = 1'b1; mPos = 0; mTp3 = -1; mClear = key_start; mStop = key_stop;
      end
    end else begin
      halt = mStop || key_stop || sw_sing_step || hlt_req || (sw_sing_inst && inst_done);
      if (key_stop) mStop = 1'b1;
      if (eTp[2]) mTp3 = mPos;
      if (eTp[3]) begin
        if (halt) begin
          mRun = 1'b0; mStop = 1'b0;
        end else begin
          mPos = 0; mTp3 = -1; mClear = 1'b0;
        end
      end else begin
        mPos++;
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    logic [3:0] eTs, eTp;
    logic eRun, eMs, eSc;
    for (int i = 0; i < n; i++) begin
      modelUpdate();
      @(posedge clk);
      @(negedge clk);
      modelOutputs(eTs, eTp, eRun, eMs, eSc);
      checkOutput("ts", 32'(ts), 32'(eTs));
      checkOutput("tp", 32'(tp), 32'(eTp));
      checkOutput("run", 32'(run), 32'(eRun));
      checkOutput("mem_start", 32'(mem_start), 32'(eMs));
      checkOutput("start_clear", 32'(start_clear), 32'(eSc));
      msCount  += int'(mem_start);
      scCount  += int'(start_clear);
      runCount += int'(run);
    end
  endtask

  task automatic clearCounts();
    msCount = 0; scCount = 0; runCount = 0;
  endtask

  task automatic pulseCont();
    key_cont = 1'b1; applyStimulus(1); key_cont = 1'b0;
  endtask

  initial begin
    clearCounts();
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(2);

    // Start with clear, run two cycles, then stop
    clearCounts();
    key_start = 1'b1; applyStimulus(1); key_start = 1'b0;
    applyStimulus(17);
    checkOutput("start_ms_pulses", 32'(msCount), 32'd2);
    checkOutput("start_sc_pulses", 32'(scCount), 32'd1);
    key_stop = 1'b1; applyStimulus(1); key_stop = 1'b0;
    applyStimulus(20);

    // Single step: one cycle per continue
    sw_sing_step = 1'b1;
    for (int r = 0; r < 2; r++) begin
      clearCounts();
      pulseCont();
      applyStimulus(20);
      checkOutput("step_run_clocks", 32'(runCount), 32'd16);
      checkOutput("step_ms_pulses", 32'(msCount), 32'd1);
      checkOutput("step_sc_pulses", 32'(scCount), 32'd0);
    end
    sw_sing_step = 1'b0;

    // Single instruction: inst_done only at the third cycle's TP4
    sw_sing_inst = 1'b1;
    clearCounts();
    pulseCont();
    applyStimulus(47);
    inst_done = 1'b1; applyStimulus(1); inst_done = 1'b0;
    applyStimulus(5);
    checkOutput("inst_run_clocks", 32'(runCount), 32'd48);
    checkOutput("inst_ms_pulses", 32'(msCount), 32'd3);
    sw_sing_inst = 1'b0;

    // io_pause over the first 10 clocks of TS3
    sw_sing_step = 1'b1;
    clearCounts();
    pulseCont();
    applyStimulus(8);
    io_pause = 1'b1; applyStimulus(10); io_pause = 1'b0;
    applyStimulus(20);
    checkOutput("pause_run_clocks", 32'(runCount), 32'd23);
    sw_sing_step = 1'b0;

    // key_stop during TS2, hlt_req at TP4, key_stop on the TP4 clock
    clearCounts();
    pulseCont();
    applyStimulus(5);
    key_stop = 1'b1; applyStimulus(1); key_stop = 1'b0;
    applyStimulus(20);
    checkOutput("stop_ts2_run_clocks", 32'(runCount), 32'd16);
    clearCounts();
    hlt_req = 1'b1;
    pulseCont();
    applyStimulus(20);
    hlt_req = 1'b0;
    checkOutput("hlt_run_clocks", 32'(runCount), 32'd16);
    clearCounts();
    pulseCont();
    applyStimulus(15);
    key_stop = 1'b1; applyStimulus(1); key_stop = 1'b0;
    applyStimulus(5);
    checkOutput("stop_tp4_run_clocks", 32'(runCount), 32'd16);

    // Reset during TS3 clock 2, then restart
    pulseCont();
    applyStimulus(9);
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    applyStimulus(2);
    clearCounts();
    pulseCont();
    applyStimulus(3);
    checkOutput("restart_ms_pulses", 32'(msCount), 32'd1);
    key_stop = 1'b1; applyStimulus(1); key_stop = 1'b0;
    applyStimulus(16);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      key_start = ($urandom_range(0, 39) == 0);
      key_cont  = ($urandom_range(0, 29) == 0);
      key_stop  = ($urandom_range(0, 59) == 0);
      hlt_req   = ($urandom_range(0, 19) == 0);
      inst_done = ($urandom_range(0, 3) == 0);
      io_pause  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) sw_sing_step = ~sw_sing_step;
      if ($urandom_range(0, 99) == 0) sw_sing_inst = ~sw_sing_inst;
      applyStimulus(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pdp8_timing_ctl.md
Name: pdp8_timing_ctl

Overview:
- Major-cycle timing sequencer for the PDP-8/I processor model.
- Generates the four time states TS1-TS4 and the time pulses TP1-TP4 that clock the register and gate datapath (NAND-gate modules, registers, memory).
- Owns the RUN flip-flop, the console START/CONT/STOP keys, single-step and single-instruction halting, HLT, and I/O-pause stretching of TS3.

Parameters:
- TS1_CLKS, 4, clocks per TS1 (legal range 2..15)
- TS2_CLKS, 4, clocks per TS2 (legal range 2..15)
- TS3_CLKS, 4, clocks per TS3 (legal range 2..15)
- TS4_CLKS, 4, clocks per TS4 (legal range 2..15)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- key_start  in  1  one-clock pulse (debounced upstream): start with clear
- key_cont  in  1  one-clock pulse: continue without clear
- key_stop  in  1  one-clock pulse: halt at end of current memory cycle
- sw_sing_step  in  1  level: halt after every memory cycle
- sw_sing_inst  in  1  level: halt after the cycle in which inst_done is high
- hlt_req  in  1  level from decoder; sampled at TP4
- inst_done  in  1  level: current cycle is the last of the instruction; sampled at TP4
- io_pause  in  1  level: stretches TS3 while high
- ts  out  4  one-hot time state: bit0=TS1 .. bit3=TS4; 0 when idle
- tp  out  4  one-clock time pulses: bit0=TP1 .. bit3=TP4
- run  out  1  RUN flip-flop
- mem_start  out  1  one-clock pulse in the first clock of TS1
- start_clear  out  1  one-clock pulse in the first clock of TS1 after key_start only

Behaviour:
- State machine states: IDLE, TS1, TS2, TS3, TS4. Each state has a 4-bit clock counter, zeroed on state entry.
- Reset (rst high at an edge): state goes to IDLE. Counter, stop_pend, ts, tp, run, mem_start and start_clear all become 0 on the next clock. Reset overrides every other input, including mid-cycle.
- IDLE transitions:
  - key_start or key_cont → next clock: TS1, run=1, mem_start=1.
  - start_clear=1 only if key_start caused the start.
  - key_start and key_cont together are treated as key_start.
- TSn lasts TSn_CLKS clocks. tp[n-1] is high during the final clock of TSn (counter == TSn_CLKS-1).
- The next state is entered on the following clock: TS1→TS2→TS3→TS4.
- ts is registered and exactly one-hot whenever state != IDLE.
- TS3 stretch: at terminal count, if io_pause=1 the counter holds and tp[2] is withheld. TP3 fires in the first clock at terminal count with io_pause=0. io_pause outside TS3 is ignored. There is no timeout.
- stop_pend:
  - Set by key_stop in any non-IDLE state, including the TP4 clock itself.
  - Cleared on entry to IDLE.
  - key_stop in IDLE is ignored.
  - key_stop in the same clock as a start in IDLE sets stop_pend, so exactly one memory cycle runs.
- Halt decision at the TP4 clock:
  - halt = stop_pend | key_stop | sw_sing_step | hlt_req | (sw_sing_inst & inst_done).
  - halt=1 → next clock: IDLE, run=0.
  - halt=0 → next clock: TS1 with mem_start pulse, start_clear=0.
- key_start and key_cont while run=1 are ignored.
- Latency from key pulse to TS1 is 1 clock. The default memory cycle is 16 clocks plus any TS3 stretch.
- Console switch changes take effect at the next TP4 only.

Test Plan:
1. rst, then key_start at clock k:
   - k+1: ts=0001, mem_start=1, start_clear=1, run=1.
   - tp[0] at k+4, tp[1] at k+8, tp[2] at k+12, tp[3] at k+16.
   - k+17: ts=0001, mem_start=1, start_clear=0.
2. sw_sing_step=1, key_cont at clock k:
   - Exactly one cycle runs, start_clear never asserts.
   - k+17: ts=0000, run=0.
   - A second key_cont repeats exactly one cycle.
3. sw_sing_inst=1, key_cont, inst_done high only during the 3rd cycle's TP4:
   - 48 clocks of cycling, then IDLE, run=0.
   - Exactly 3 mem_start pulses.
4. io_pause held high for the first 10 clocks of TS3, defaults otherwise:
   - tp[2] fires in TS3 clock 11.
   - The cycle is 23 clocks long.
   - tp[3] follows 4 clocks later.
5. key_stop pulsed during TS2:
   - The cycle completes with normal TP3 and TP4, then IDLE.
   - Separately, hlt_req=1 at TP4 gives the same halt.
   - key_stop on the TP4 clock also halts.
6. rst during TS3 clock 2:
   - Next clock: ts=0, tp=0, run=0, mem_start=0.
   - A key_cont two clocks later restarts cleanly at TS1 with mem_start=1.
